// File: rtl/hdmi_audio_pkg.sv
// ----------------------------------------------------------------------------
// hdmi_audio_pkg : shared types, constants and sample helpers -- Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hdmi_audio_pkg;

  localparam int ACC_W = 27;
  localparam logic [8:0] GAIN_ONE  = 9'd256;
  localparam logic [8:0] GAIN_STEP = 9'd16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2
  } fade_state_t;

  // Clamp a 17-bit signed value into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? 16'sh8000 : 16'sh7FFF;
    end
    return v[15:0];
  endfunction

  function automatic logic signed [15:0] vol_shift(input logic signed [15:0] x,
                                                   input logic [1:0] v);
    case (v)
      2'd3:    return x;
      2'd2:    return x >>> 1;
      2'd1:    return x >>> 2;
      default: return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_tick_gen.sv
// ----------------------------------------------------------------------------
// audio_tick_gen : fractional divider producing the audio clock and sample tick -- Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module audio_tick_gen
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ_PAL  = 31500000,
  parameter int unsigned CLK_HZ_NTSC = 32727272,
  parameter int unsigned AUDIO_RATE  = 48000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ntscmode,
  output logic clk_audio,
  output logic tick
);

  localparam logic [ACC_W-1:0] INC      = ACC_W'(2 * AUDIO_RATE);
  localparam logic [ACC_W-1:0] MOD_PAL  = ACC_W'(CLK_HZ_PAL);
  localparam logic [ACC_W-1:0] MOD_NTSC = ACC_W'(CLK_HZ_NTSC);

  logic [ACC_W-1:0] r_acc;
  logic             r_ntsc;
  logic             r_clk_audio;
  logic [ACC_W-1:0] w_mod;
  logic [ACC_W-1:0] w_sum;
  logic             w_mode_chg;
  logic             w_wrap;

  assign w_mod      = r_ntsc ? MOD_NTSC : MOD_PAL;
  assign w_sum      = r_acc + INC;
  assign w_mode_chg = (ntscmode != r_ntsc);
  assign w_wrap     = !w_mode_chg && (w_sum >= w_mod);

  // A mode change restarts the phase from zero and suppresses that cycle's toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_ntsc      <= 1'b0;
      r_clk_audio <= 1'b0;
    end else if (w_mode_chg) begin
      r_acc  <= '0;
      r_ntsc <= ntscmode;
    end else if (w_wrap) begin
      r_acc       <= w_sum - w_mod;
      r_clk_audio <= ~r_clk_audio;
    end else begin
      r_acc <= w_sum;
    end
  end

  assign clk_audio = r_clk_audio;
  assign tick      = w_wrap && !r_clk_audio;

endmodule

`default_nettype wire

// File: rtl/hdmi_audio_ctrl.sv
// ----------------------------------------------------------------------------
// hdmi_audio_ctrl : HDMI audio clock, volume scaling and click-free fades -- Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hdmi_audio_ctrl
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ_PAL  = 31500000,
  parameter int unsigned CLK_HZ_NTSC = 32727272,
  parameter int unsigned AUDIO_RATE  = 48000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ntscmode,
  input  logic signed [17:0] audio_l,
  input  logic signed [17:0] audio_r,
  input  logic        [1:0]  volume,
  output logic               clk_audio,
  output logic signed [15:0] sample_l,
  output logic signed [15:0] sample_r,
  output logic               sample_stb,
  output logic               fading
);

  logic tick;

  audio_tick_gen #(
    .CLK_HZ_PAL (CLK_HZ_PAL),
    .CLK_HZ_NTSC(CLK_HZ_NTSC),
    .AUDIO_RATE (AUDIO_RATE)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .ntscmode (ntscmode),
    .clk_audio(clk_audio),
    .tick     (tick)
  );

  fade_state_t        r_state;
  logic        [8:0]  r_gain;
  logic        [1:0]  r_vol_act;

  logic               r_v1;
  logic               r_v2;
  logic signed [15:0] r_x_l;
  logic signed [15:0] r_x_r;
  logic signed [15:0] r_y_l;
  logic signed [15:0] r_y_r;

  logic signed [25:0] w_y_l_ext;
  logic signed [25:0] w_y_r_ext;
  logic signed [25:0] w_gain_ext;
  logic signed [25:0] w_prod_l;
  logic signed [25:0] w_prod_r;
  logic               w_unused;

  assign w_y_l_ext  = 26'(r_y_l);
  assign w_y_r_ext  = 26'(r_y_r);
  assign w_gain_ext = {17'd0, r_gain};
  assign w_prod_l   = w_y_l_ext * w_gain_ext;
  assign w_prod_r   = w_y_r_ext * w_gain_ext;

  // Gain never exceeds 256, so bits [23:8] already hold the full-range result.
  assign w_unused = ^{audio_l[0], audio_r[0], w_prod_l[25:24], w_prod_l[7:0],
                      w_prod_r[25:24], w_prod_r[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_x_l      <= '0;
      r_x_r      <= '0;
      r_y_l      <= '0;
      r_y_r      <= '0;
      sample_l   <= '0;
      sample_r   <= '0;
      sample_stb <= 1'b0;
    end else begin
      r_v1       <= tick;
      r_v2       <= r_v1;
      sample_stb <= r_v2;
      if (tick) begin
        r_x_l <= sat16(audio_l[17:1]);
        r_x_r <= sat16(audio_r[17:1]);
      end
      if (r_v1) begin
        r_y_l <= vol_shift(r_x_l, r_vol_act);
        r_y_r <= vol_shift(r_x_r, r_vol_act);
      end
      if (r_v2) begin
        sample_l <= w_prod_l[23:8];
        sample_r <= w_prod_r[23:8];
      end
    end
  end

  // Volume only switches at zero gain so the step is inaudible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_FADE_OUT;
      r_gain    <= '0;
      r_vol_act <= '0;
      fading    <= 1'b1;
    end else if (tick) begin
      case (r_state)
        ST_RUN: begin
          if (volume != r_vol_act) begin
            r_state <= ST_FADE_OUT;
            fading  <= 1'b1;
          end
        end
        ST_FADE_OUT: begin
          if (r_gain == '0) begin
            r_vol_act <= volume;
            if (volume != 2'd0) begin
              r_state <= ST_FADE_IN;
              fading  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              fading  <= 1'b0;
            end
          end else if (r_gain >= GAIN_STEP) begin
            r_gain <= r_gain - GAIN_STEP;
          end else begin
            r_gain <= '0;
          end
        end
        ST_FADE_IN: begin
          if (volume != r_vol_act) begin
            r_state <= ST_FADE_OUT;
          end else if (r_gain >= GAIN_ONE - GAIN_STEP) begin
            r_gain  <= GAIN_ONE;
            r_state <= ST_RUN;
            fading  <= 1'b0;
          end else begin
            r_gain <= r_gain + GAIN_STEP;
          end
        end
        default: begin
          r_state <= ST_FADE_OUT;
          fading  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_audio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hdmi_audio_ctrl : directed self-checking bench for hdmi_audio_ctrl -- Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hdmi_audio_ctrl;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ntscmode = 1'b0;
  logic signed [17:0] audio_l;
  logic signed [17:0] audio_r;
  logic        [1:0]  volume;
  logic               clk_audio;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic               sample_stb;
  logic               fading;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int stb_seen = 0;
  int tq[$];
  logic prev_ca = 1'b0;
  int bad;
  int chg;
  int stb0;
  int n;
  logic ca_before;

  always #5 clk = ~clk;

  hdmi_audio_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ntscmode  (ntscmode),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .volume    (volume),
    .clk_audio (clk_audio),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .sample_stb(sample_stb),
    .fading    (fading)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clk_audio !== prev_ca) begin
      tq.push_back(cyc);
      if (clk_audio) last_rise = cyc;
    end
    prev_ca = clk_audio;
    if (sample_stb) stb_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_stb();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_stb && k < 2000);
    if (!sample_stb) check("stb_timeout", 0, 1);
  endtask

  task automatic wait_rise();
    int k = 0;
    logic p;
    p = clk_audio;
    do begin
      @(negedge clk);
      k++;
      if (!p && clk_audio) break;
      p = clk_audio;
    end while (k < 2000);
    if (k >= 2000) check("rise_timeout", 0, 1);
  endtask

  initial begin
    audio_l = 18'sd4096;
    audio_r = -18'sd4096;
    volume  = 2'd3;
    repeat (5) @(negedge clk);
    check("rst_clk_audio", clk_audio, 0);
    check("rst_sample_l", sample_l, 0);
    check("rst_sample_r", sample_r, 0);
    check("rst_stb", sample_stb, 0);
    check("rst_fading", fading, 1);

    // Power-up: latch tick at gain 0, then 16 steps to unity gain.
    reset_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      wait_stb();
      check("pwr_l", sample_l, 128 * (k - 1));
      check("pwr_r", sample_r, -128 * (k - 1));
      check("pwr_fading", fading, (k == 17) ? 0 : 1);
      if (k == 1) begin
        check("latency", cyc - last_rise, 2);
        @(negedge clk);
        check("stb_width", sample_stb, 0);
      end
    end

    bad = 0;
    for (int i = 1; i < tq.size(); i++)
      if (!((tq[i] - tq[i-1]) inside {328, 329})) bad++;
    check("pal_period_bad", bad, 0);
    check("pal_toggle_cnt_ok", (tq.size() >= 21) ? 1 : 0, 1);
    if (tq.size() >= 21) begin
      check("pal_span8_a", tq[8] - tq[0], 2625);
      check("pal_span8_b", tq[20] - tq[12], 2625);
    end

    // Saturation and rounding-toward-minus-infinity at full volume.
    audio_l = 18'h1FFFE;
    audio_r = -18'sd4;
    wait_stb();
    check("max_l", sample_l, 32767);
    check("neg_r", sample_r, -2);
    check("latency2", cyc - last_rise, 2);
    audio_l = 18'h20000;
    wait_stb();
    check("min_l", sample_l, -32768);

    // Volume 3 -> 1: fade out, latch, fade in.
    audio_l = 18'sd1000;
    audio_r = 18'sd4096;
    volume  = 2'd1;
    wait_stb();
    check("fo_start_r", sample_r, 2048);
    check("fo_start_fading", fading, 1);
    for (int k = 1; k <= 16; k++) begin
      wait_stb();
      check("fo_r", sample_r, 8 * (256 - 16 * k));
    end
    wait_stb();
    check("latch_r", sample_r, 0);
    check("latch_fading", fading, 1);
    for (int k = 1; k <= 16; k++) begin
      wait_stb();
      check("fi_r", sample_r, 32 * k);
    end
    check("fi_final_l", sample_l, 125);
    check("fi_final_fading", fading, 0);

    // Switch to NTSC exactly when a toggle is due; it must be suppressed.
    n = 0;
    while (dut.u_tick.r_acc < 31500000 - 96000 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ca_before = clk_audio;
    ntscmode = 1'b1;
    tq.delete();
    @(negedge clk);
    chg = cyc;
    check("ntsc_acc_clear", dut.u_tick.r_acc, 0);
    check("ntsc_no_toggle", clk_audio, ca_before);
    n = 0;
    while (tq.size() < 7 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ntsc_toggle_cnt_ok", (tq.size() >= 7) ? 1 : 0, 1);
    if (tq.size() >= 7) begin
      check("ntsc_first", tq[0] - chg, 341);
      bad = 0;
      for (int i = 1; i < 7; i++)
        if (!((tq[i] - tq[i-1]) inside {340, 341})) bad++;
      check("ntsc_period_bad", bad, 0);
    end

    // Fade out to gain 128, then reset with a sample in flight.
    wait_stb();
    volume = 2'd3;
    wait_stb();
    check("mf_start_r", sample_r, 512);
    for (int k = 1; k <= 8; k++) wait_stb();
    check("mf_gain128_r", sample_r, 256);
    wait_rise();
    reset_n = 1'b0;
    #1;
    stb0 = stb_seen;
    check("mrst_l", sample_l, 0);
    check("mrst_r", sample_r, 0);
    check("mrst_stb", sample_stb, 0);
    check("mrst_fading", fading, 1);
    check("mrst_clk_audio", clk_audio, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("no_stray_stb", stb_seen - stb0, 0);
    wait_stb();
    check("post_rst_latch_r", sample_r, 0);
    check("post_rst_fading", fading, 1);
    wait_stb();
    check("post_rst_step_r", sample_r, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hdmi_audio_ctrl.md
HDMI_AUDIO_CTRL -- requirements
Module: hdmi_audio_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ_PAL, default 31500000, pixel clock rate in PAL mode.
REQ-002 SHALL have parameter CLK_HZ_NTSC, default 32727272, pixel clock rate in NTSC mode.
REQ-003 SHALL have parameter AUDIO_RATE, default 48000, output sample rate in Hz; 2*AUDIO_RATE < both clock rates.
REQ-004 SHALL have port clk, in, 1, pixel clock and the only clock.
REQ-005 SHALL have port reset_n, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port ntscmode, in, 1, selects CLK_HZ_NTSC (1) or CLK_HZ_PAL (0) as the divider modulus.
REQ-007 SHALL have ports audio_l and audio_r, in, 18 each, signed core audio sampled on the sample tick.
REQ-008 SHALL have port volume, in, 2: 0 mute, 1 is 1/4, 2 is 1/2, 3 is full.
REQ-009 SHALL have port clk_audio, out, 1, 48 kHz square wave for the HDMI audio clock.
REQ-010 SHALL have ports sample_l and sample_r, out, 16 each, signed scaled samples.
REQ-011 SHALL have port sample_stb, out, 1, one-cycle pulse when sample_l and sample_r update.
REQ-012 SHALL have port fading, out, 1, high while the state is not RUN.

Function
REQ-013 Tick generator SHALL add 2*AUDIO_RATE to a 27-bit accumulator every clk; when the sum is at least the modulus, it SHALL store sum-modulus and toggle clk_audio in that same cycle.
REQ-014 Sample tick SHALL be the cycle in which clk_audio toggles 0->1; average toggle period SHALL be exactly modulus/(2*AUDIO_RATE) cycles with no drift.
REQ-015 When ntscmode differs from its registered value, the accumulator SHALL clear to 0 in the next cycle; no toggle SHALL occur in that cycle, and clk_audio SHALL hold its level.
REQ-016 Stage 1, at the sample-tick edge: x = audio >>> 1 (17-bit), saturated to 16-bit signed [-32768, 32767].
REQ-017 Stage 2, one cycle later: y = x >>> (3 - vol_act) for vol_act 1..3, y = 0 for vol_act 0; out = (y * gain) >>> 8; gain is unsigned 9-bit in 0..256; the product is 25-bit signed.
REQ-018 sample_l, sample_r and sample_stb SHALL update at the edge 2 cycles after the sample-tick edge (latency 2); sample_stb SHALL be high for exactly 1 cycle per tick.
REQ-019 FSM states are RUN, FADE_OUT and FADE_IN; gain and state change only at sample-tick edges, and the gain used is the value in effect at stage 2.
REQ-020 RUN: if volume != vol_act, go to FADE_OUT; otherwise hold.
REQ-021 FADE_OUT: gain = max(gain-16, 0); when gain is already 0, set vol_act := volume, then go to FADE_IN if volume != 0, else go to RUN with gain 0.
REQ-022 FADE_IN: gain = min(gain+16, 256); when gain reaches 256, go to RUN; if volume != vol_act, go to FADE_OUT from the current gain.
REQ-023 Volume changes during FADE_OUT SHALL be absorbed; only the value present at gain==0 is latched.
REQ-024 A full fade-out from gain 256 SHALL take 16 ticks plus 1 latch tick; a full fade-in SHALL take 16 ticks.

Reset
REQ-025 reset_n low SHALL asynchronously set: accumulator 0, clk_audio 0, sample_l/sample_r 0, sample_stb 0, pipeline 0, gain 0, vol_act 0, state FADE_OUT (fading 1).
REQ-026 After reset release, the first sample tick SHALL latch volume and start a fade-in, giving a click-free power-up.
REQ-027 Reset assertion mid-fade or mid-pipeline SHALL discard all in-flight data, and no sample_stb SHALL be produced.

Structure
REQ-028 Package hdmi_audio_pkg SHALL hold the FSM state enum, GAIN_ONE=256, GAIN_STEP=16 and ACC_W=27.
REQ-029 Tick generation (REQ-013 to REQ-015) SHALL be a sub-module, audio_tick_gen; the saturation, scaling and FSM logic stays in hdmi_audio_ctrl.

Verification
REQ-030 PAL, ntscmode=0 -> every 8 consecutive toggles span exactly 2625 cycles; each period is 328 or 329 cycles.
REQ-031 volume=3, state RUN, audio_l=18'h1FFFE -> sample_l=16'h7FFF; audio_r=-4 -> sample_r=-2; both appear 2 cycles after the tick with one stb pulse.
REQ-032 Reset release with volume=3 -> gain 0 on tick 1, then 16,32,...,256 over ticks 2-17, then RUN; fading drops in the cycle after gain reaches 256.
REQ-033 In RUN, volume 3->1 -> 16 ticks of fade-out, vol_act=1 at the latch tick, then 16 ticks of fade-in; final input 1000 -> output 125.
REQ-034 ntscmode toggled mid-period -> accumulator is 0 next cycle with no toggle in that cycle, then periods track the NTSC modulus (340 or 341 cycles).
REQ-035 reset_n pulsed low mid-fade at gain 128 -> all outputs immediately 0, state FADE_OUT, and no stray sample_stb.
